// File: rtl/fsk_cpfsk_tx.sv
// Continuous-phase binary FSK transmitter: 1-deep bit holding register, phase-accumulator NCO, quarter-wave sine LUT.
// Define FSK_PRBS_EN to source symbols from an internal PRBS-7 instead of the data_in/data_valid handshake.
module fsk_cpfsk_tx #(
  parameter int SYM_LEN  = 2048,
  parameter int PHASE_W  = 16,
  parameter int INC_ONE  = 256,
  parameter int INC_ZERO = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        data_in,
  input  logic        data_valid,
  output logic        data_ready,
  output logic [10:0] shuchu,
  output logic        code,
  output logic        sym_strobe,
  output logic        busy,
  output logic        underrun
);

  localparam int CNT_W = $clog2(SYM_LEN);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     counter, counter_nxt;
  logic [PHASE_W-1:0]   phase, phase_nxt;
  logic [PHASE_W-1:0]   inc;
  logic                 load;
  logic                 load_bit;
  logic                 last;

  assign inc  = code ? PHASE_W'(INC_ONE) : PHASE_W'(INC_ZERO);
  assign last = (counter == CNT_W'(SYM_LEN - 1));

  always_comb begin
    state_nxt   = state;
    counter_nxt = counter;
    phase_nxt   = phase;
    load        = 1'b0;
    busy        = 1'b0;
    sym_strobe  = 1'b0;
    case (state)
      IDLE: begin
        counter_nxt = '0;
        phase_nxt   = '0;
        if (enable) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (!enable) begin
          state_nxt   = IDLE;
          counter_nxt = '0;
          phase_nxt   = '0;
        end else begin
          // phase keeps running across symbol boundaries for continuity
          phase_nxt = phase + inc;
          if (last) begin
            sym_strobe  = 1'b1;
            load        = 1'b1;
            counter_nxt = '0;
          end else begin
            counter_nxt = counter + CNT_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      counter <= '0;
      phase   <= '0;
    end else begin
      state   <= state_nxt;
      counter <= counter_nxt;
      phase   <= phase_nxt;
    end
  end

`ifdef FSK_PRBS_EN
  logic [6:0] prbs;
  logic       unused_inputs;

  assign unused_inputs = data_in ^ data_valid;
  assign data_ready    = 1'b0;
  assign underrun      = 1'b0;
  assign load_bit      = prbs[6];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prbs <= 7'h7F;
    end else if (load) begin
      prbs <= {prbs[5:0], prbs[6] ^ prbs[5]};
    end
  end
`else
  logic full;
  logic hold;
  logic accept;

  assign data_ready = !full;
  assign accept     = data_valid && !full;
  // an empty holding register at load time sends idle bit 1
  assign load_bit   = full ? hold : 1'b1;
  assign underrun   = load && !full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      hold <= 1'b0;
    end else begin
      if (accept) begin
        full <= 1'b1;
        hold <= data_in;
      end else if (load && full) begin
        full <= 1'b0;
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code <= 1'b1;
    end else if (load) begin
      code <= load_bit;
    end
  end

  function automatic logic [6:0] sine_lut(input logic [6:0] i);
    logic [6:0] v;
    case (i)
      7'd0:  v = 7'd0;   7'd1:  v = 7'd3;   7'd2:  v = 7'd6;   7'd3:  v = 7'd9;
      7'd4:  v = 7'd12;  7'd5:  v = 7'd16;  7'd6:  v = 7'd19;  7'd7:  v = 7'd22;
      7'd8:  v = 7'd25;  7'd9:  v = 7'd28;  7'd10: v = 7'd31;  7'd11: v = 7'd34;
      7'd12: v = 7'd37;  7'd13: v = 7'd40;  7'd14: v = 7'd43;  7'd15: v = 7'd46;
      7'd16: v = 7'd49;  7'd17: v = 7'd51;  7'd18: v = 7'd54;  7'd19: v = 7'd57;
      7'd20: v = 7'd60;  7'd21: v = 7'd63;  7'd22: v = 7'd65;  7'd23: v = 7'd68;
      7'd24: v = 7'd71;  7'd25: v = 7'd73;  7'd26: v = 7'd76;  7'd27: v = 7'd78;
      7'd28: v = 7'd81;  7'd29: v = 7'd83;  7'd30: v = 7'd85;  7'd31: v = 7'd88;
      7'd32: v = 7'd90;  7'd33: v = 7'd92;  7'd34: v = 7'd94;  7'd35: v = 7'd96;
      7'd36: v = 7'd98;  7'd37: v = 7'd100; 7'd38: v = 7'd102; 7'd39: v = 7'd104;
      7'd40: v = 7'd106; 7'd41: v = 7'd107; 7'd42: v = 7'd109; 7'd43: v = 7'd111;
      7'd44: v = 7'd112; 7'd45: v = 7'd113; 7'd46: v = 7'd115; 7'd47: v = 7'd116;
      7'd48: v = 7'd117; 7'd49: v = 7'd118; 7'd50: v = 7'd120; 7'd51: v = 7'd121;
      7'd52: v = 7'd122; 7'd53: v = 7'd122; 7'd54: v = 7'd123; 7'd55: v = 7'd124;
      7'd56: v = 7'd125; 7'd57: v = 7'd125; 7'd58: v = 7'd126; 7'd59: v = 7'd126;
      7'd60: v = 7'd126; 7'd61: v = 7'd127; 7'd62: v = 7'd127; 7'd63: v = 7'd127;
      7'd64: v = 7'd127;
      default: v = 7'd0;
    endcase
    return v;
  endfunction

  logic [7:0] idx;
  logic [6:0] lut_addr;
  logic [6:0] mag_q;
  logic       neg_q;
  logic [7:0] samp;

  assign idx      = phase[PHASE_W-1 -: 8];
  // quadrants 1 and 3 read the quarter wave mirrored
  assign lut_addr = idx[6] ? (7'd64 - {1'b0, idx[5:0]}) : {1'b0, idx[5:0]};
  assign samp     = neg_q ? (8'd128 - {1'b0, mag_q}) : (8'd128 + {1'b0, mag_q});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag_q  <= '0;
      neg_q  <= 1'b0;
      shuchu <= 11'd128;
    end else begin
      mag_q  <= sine_lut(lut_addr);
      neg_q  <= idx[7];
      shuchu <= {3'b000, samp};
    end
  end

endmodule

// File: tb/tb_fsk_cpfsk_tx.sv
// Randomised bench for fsk_cpfsk_tx against a $sin-based cycle model, plus directed symbol/abort/reset scenarios.
module tb_fsk_cpfsk_tx;

  localparam int SYM_LEN = 2048;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        data_in;
  logic        data_valid;
  logic        data_ready;
  logic [10:0] shuchu;
  logic        code;
  logic        sym_strobe;
  logic        busy;
  logic        underrun;

  always #5 clk = ~clk;

  fsk_cpfsk_tx dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .shuchu     (shuchu),
    .code       (code),
    .sym_strobe (sym_strobe),
    .busy       (busy),
    .underrun   (underrun)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // behavioural model state
  int m_run, m_cnt, m_phase, m_code, m_full, m_hold, m_st1, m_sh, m_acc;
  logic [6:0] m_prbs;
  // last observed outputs
  int o_sh, o_code, o_busy, o_strobe, o_under, o_ready;

  function automatic int sample(input int ph);
    int  idx, m;
    real s;
    idx = (ph >> 8) & 255;
    s   = $sin(3.14159265358979 * idx / 128.0);
    m   = $rtoi(127.0 * (s < 0.0 ? -s : s) + 0.5);
    return (s < 0.0) ? 128 - m : 128 + m;
  endfunction

  task automatic model_reset();
    m_run = 0; m_cnt = 0; m_phase = 0; m_code = 1; m_full = 0; m_hold = 0;
    m_st1 = 128; m_sh = 128; m_acc = 0; m_prbs = 7'h7F;
  endtask

  task automatic tick();
    int ld, lbit, e_ready, e_under, e_strobe, e, o, nst1;
    @(negedge clk);
    ld = (enable && (m_run == 0 || m_cnt == SYM_LEN - 1)) ? 1 : 0;
`ifdef FSK_PRBS_EN
    e_ready = 0;
    e_under = 0;
    lbit    = m_prbs[6];
`else
    e_ready = m_full ? 0 : 1;
    e_under = (ld && !m_full) ? 1 : 0;
    lbit    = m_full ? m_hold : 1;
`endif
    e_strobe = (m_run && enable && m_cnt == SYM_LEN - 1) ? 1 : 0;
    e = (m_sh << 5) | (m_code << 4) | (m_run << 3) | (e_strobe << 2) | (e_under << 1) | e_ready;
    o_sh = shuchu; o_code = code; o_busy = busy; o_strobe = sym_strobe;
    o_under = underrun; o_ready = data_ready;
    o = (o_sh << 5) | (o_code << 4) | (o_busy << 3) | (o_strobe << 2) | (o_under << 1) | o_ready;
    chk("cycle", o, e);
    // advance model by one clock
    nst1 = sample(m_phase);
    m_sh = m_st1;
    m_st1 = nst1;
    if (m_run == 0) begin
      m_phase = 0; m_cnt = 0;
      if (enable) begin m_run = 1; m_code = lbit; end
    end else if (!enable) begin
      m_run = 0; m_cnt = 0; m_phase = 0;
    end else begin
      m_phase = (m_phase + (m_code ? 256 : 1024)) % 65536;
      if (m_cnt == SYM_LEN - 1) begin m_cnt = 0; m_code = lbit; end
      else m_cnt++;
    end
`ifdef FSK_PRBS_EN
    m_acc = 0;
    if (ld) m_prbs = {m_prbs[5:0], m_prbs[6] ^ m_prbs[5]};
`else
    m_acc = (data_valid && !m_full) ? 1 : 0;
    if (m_acc) begin m_full = 1; m_hold = data_in; end
    else if (ld && m_full) m_full = 0;
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c128_a, c128_b, n_strobe, n_under, maxd, prev, d, guard, pvalid;
    rst = 1'b1; enable = 1'b0; data_in = 1'b0; data_valid = 1'b0;
    model_reset();
    #12;
    chk("rst_shuchu", shuchu, 128);
    chk("rst_ready", data_ready,
`ifdef FSK_PRBS_EN
        0);
`else
        1);
`endif
    chk("rst_busy", busy, 0);
    chk("rst_code", code, 1);
    chk("rst_strobe", sym_strobe, 0);
    chk("rst_underrun", underrun, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    chk("idle_shuchu", o_sh, 128);
    chk("idle_busy", o_busy, 0);

`ifndef FSK_PRBS_EN
    // push 1, then 0 with enable: tone 1 then tone 0, then starvation
    data_valid = 1'b1; data_in = 1'b1;
    tick();
    data_in = 1'b0; enable = 1'b1;
    c128_a = 0; c128_b = 0; n_strobe = 0; n_under = 0; maxd = 0; prev = 128;
    for (int k = 0; k <= 4100; k++) begin
      tick();
      if (m_acc) data_valid = 1'b0;
      if (k >= 3 && k <= 2050 && o_sh == 128) c128_a++;
      if (k >= 2051 && k <= 4098 && o_sh == 128) c128_b++;
      if (o_strobe) n_strobe++;
      if (o_under) n_under++;
      if (k == 2048) chk("strobe_at_2048", o_strobe, 1);
      if (k == 4096) chk("underrun_at_load", o_under, 1);
      if (k == 100) chk("code_sym1", o_code, 1);
      if (k == 2100) chk("code_sym2", o_code, 0);
      if (k == 4098) chk("code_starved", o_code, 1);
      d = (o_sh > prev) ? o_sh - prev : prev - o_sh;
      if (k >= 2040 && k <= 2070 && d > maxd) maxd = d;
      prev = o_sh;
    end
    chk("mid_cnt_bit1", c128_a, 16);
    chk("mid_cnt_bit0", c128_b, 64);
    chk("strobe_count", n_strobe, 2);
    chk("underrun_count", n_under, 1);
    chk("phase_continuity", (maxd <= 13) ? 1 : 0, 1);
    chk("ready_starved", o_ready, 1);

    // abort at counter 1000 with a held bit, then re-enable
    data_valid = 1'b1; data_in = 1'b0;
    tick();
    data_valid = 1'b0;
    guard = 0;
    while (m_cnt != 1000 && guard < 3 * SYM_LEN) begin tick(); guard++; end
    chk("reach_cnt1000", (guard < 3 * SYM_LEN) ? 1 : 0, 1);
    enable = 1'b0;
    tick();
    tick();
    chk("abort_busy", o_busy, 0);
    tick(); tick();
    chk("abort_shuchu", o_sh, 128);
    chk("abort_held", o_ready, 0);
    enable = 1'b1;
    tick();
    tick();
    chk("reenable_code", o_code, 0);
    tick(); tick();
    chk("restart_mid", o_sh, 128);
    tick();
    chk("restart_first", o_sh, 140);
`endif

    // randomised traffic with occasional aborts and starved stretches
    enable = 1'b1;
    pvalid = 4;
    for (int k = 0; k < 8 * SYM_LEN; k++) begin
      if (k % SYM_LEN == 0) pvalid = ($urandom_range(0, 3) == 0) ? 5000 : 4;
      enable     = ($urandom_range(0, 2999) != 0);
      data_valid = ($urandom_range(1, pvalid) == 1);
      data_in    = $urandom_range(0, 1);
      tick();
    end

    // asynchronous reset in the middle of a symbol
    enable = 1'b1; data_valid = 1'b1; data_in = 1'b0;
    for (int k = 0; k < 700; k++) tick();
    data_valid = 1'b0;
    #2;
    rst = 1'b1; enable = 1'b0;
    #1;
    chk("arst_shuchu", shuchu, 128);
    chk("arst_busy", busy, 0);
    chk("arst_code", code, 1);
    model_reset();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fsk_cpfsk_tx.md
# fsk_cpfsk_tx

Continuous-phase binary FSK transmitter. It takes one data bit per symbol through a valid/ready handshake and synthesises an 11-bit offset-binary sine on `shuchu` with a phase-accumulator NCO and a quarter-wave LUT. The carrier frequency is selected per symbol. It is the transmit end of the FSK link: the zero-crossing demodulator counts mid-scale (11'd128) samples per 2048-clock symbol, and few crossings are decoded as 1.

## Interface
- `SYM_LEN`, 2048: clocks per symbol.
- `PHASE_W`, 16: phase accumulator width; top 8 bits address the sine.
- `INC_ONE`, 256: phase increment for bit 1 (8 cycles/symbol, low tone).
- `INC_ZERO`, 1024: phase increment for bit 0 (32 cycles/symbol, high tone).
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  transmit enable.
- `data_in`  in  1  next bit to send.
- `data_valid`  in  1  `data_in` valid.
- `data_ready`  out  1  holding register empty.
- `shuchu`  out  11  modulated sample, offset binary, mid-scale 128, range 1..255, bits [10:8] always 0.
- `code`  out  1  bit currently being transmitted.
- `sym_strobe`  out  1  one-cycle pulse on the last clock of each symbol.
- `busy`  out  1  high in RUN.
- `underrun`  out  1  one-cycle pulse when a symbol starts with no data available.

## Operation
- **Holding register:** one bit deep, with a full flag.
  - `data_ready = !full`.
  - A bit is accepted when `data_valid && data_ready`.
  - A bit is consumed at symbol load.
  - Accept and consume in the same cycle is impossible: ready is low while full, so ready reasserts the cycle after consume.
- **Symbol load:** takes the holding bit if full. If empty, it sends idle bit 1 and pulses `underrun`.
- **State machine:**
  - IDLE: counter = 0, phase = 0, `busy` = 0. When `enable`=1: load symbol into `code`, go to RUN.
  - RUN, each cycle:
    - `phase += (code ? INC_ONE : INC_ZERO)`, mod 2^PHASE_W.
    - `counter++`.
    - At counter == SYM_LEN-1: pulse `sym_strobe`, counter -> 0, load next symbol.
  - RUN with `enable`=0: abort immediately to IDLE. Counter and phase clear. The holding register is retained.
- **Phase continuity:** phase is never reset at symbol boundaries, only on IDLE.
- **Sine generation:**
  - idx = phase[PHASE_W-1 -: 8]; q = idx[7:6]; k = idx[5:0].
  - LUT has 65 entries, LUT[i] = round(127·sin(πi/128)), i = 0..64. LUT[0] = 0, LUT[64] = 127, every other entry nonzero.
  - mag = LUT[k] for q = 0 or 2; LUT[64-k] for q = 1 or 3.
  - Sample = 128+mag for q = 0 or 1; 128−mag for q = 2 or 3. Zero-extended to 11 bits.
- **Mid-scale samples:** exactly 128 only at idx 0 and 128. This gives 16 per symbol for bit 1 and 64 for bit 0.
- **IDLE output:** `shuchu` held at 128.

## Timing
- **Reset values:** `shuchu`=128, `code`=1, `data_ready`=1, `sym_strobe`=0, `busy`=0, `underrun`=0. Phase, counter and full flag are 0. State is IDLE.
- **Pipeline:** phase register -> LUT/magnitude register -> `shuchu` register. `shuchu` reflects the phase with 2 cycles of latency.
- **Frequency switch:** `code` changes on the cycle after `sym_strobe`. The new increment applies from that cycle.
- **First symbol:** the first bit is loaded on the first clock with `enable`=1 in IDLE. The first non-128 sample appears 3 cycles later.
- **Reset mid-symbol:** all state returns to reset values asynchronously. The holding bit is lost.

## Configuration
- `FSK_PRBS_EN` defined:
  - An internal PRBS-7 (x^7+x^6+1, seed 7'h7F, one step per symbol load) supplies every symbol.
  - `data_in`/`data_valid` are ignored, `data_ready` is held 0, and `underrun` never fires.
- Undefined: external handshake as above.

## Test plan
- Reset then idle: `shuchu`=128, `data_ready`=1, `busy`=0 for 100 cycles with `enable`=0.
- Push 1, then 0, then enable: `code`=1 for 2048 clocks with exactly 16 samples ==128; next symbol `code`=0 with 64 samples ==128. `sym_strobe` every 2048 clocks.
- Phase continuity: at the 1->0 boundary, consecutive `shuchu` samples differ by ≤13 (no step jump).
- Starve input after one bit: the second symbol sends 1 and `underrun` pulses once on its load cycle. `data_ready` stays 1.
- Deassert `enable` at counter 1000: next cycle `busy`=0; `shuchu`=128 within 3 cycles. Re-enable restarts at phase 0, and the held bit is sent.
- `FSK_PRBS_EN`: the first 8 transmitted bits match the PRBS-7 sequence from seed 7'h7F; `data_ready`=0 throughout.
